// File: rtl/fp_divider.sv
// fp_divider: multi-cycle IEEE-754 binary32 divider.
// Operands are captured on a start pulse. The mantissa quotient comes from a
// radix-2 restoring loop that produces one bit per cycle. The quotient is then
// normalized and truncated, and the result is registered with a one-cycle done.
// Denormal operands are flushed to zero. NaN results are the canonical quiet NaN.

module fp_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    NORM,
    FIN
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_t            state;
  logic              sign;
  logic [23:0]       m2;
  logic [25:0]       r;
  logic [24:0]       q;
  logic signed [9:0] exp_e;
  logic [4:0]        cnt;
  logic [31:0]       spec_res;
  logic              spec_dbz;

  // Raw field split of the incoming operands
  logic [7:0]  e1;
  logic [7:0]  e2;
  logic [22:0] f1;
  logic [22:0] f2;

  assign e1 = data1[30:23];
  assign e2 = data2[30:23];
  assign f1 = data1[22:0];
  assign f2 = data2[22:0];

  // Operand classification; exponent field 0 counts as zero
  logic a_zero;
  logic a_inf;
  logic a_nan;
  logic b_zero;
  logic b_inf;
  logic b_nan;
  logic in_special;
  logic in_sign;
  logic signed [9:0] in_exp;

  assign a_zero     = (e1 == 8'h00);
  assign a_inf      = (e1 == 8'hFF) && (f1 == 23'h0);
  assign a_nan      = (e1 == 8'hFF) && (f1 != 23'h0);
  assign b_zero     = (e2 == 8'h00);
  assign b_inf      = (e2 == 8'hFF) && (f2 == 23'h0);
  assign b_nan      = (e2 == 8'hFF) && (f2 != 23'h0);
  assign in_special = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;
  assign in_sign    = data1[31] ^ data2[31];
  assign in_exp     = $signed({2'b00, e1} - {2'b00, e2} + 10'd127);

  logic [31:0] dec_res;
  logic        dec_dbz;

  // Special-case result, evaluated in priority order at capture time
  always_comb begin
    dec_res = {in_sign, 31'h0};
    dec_dbz = 1'b0;
    if (a_nan || b_nan) begin
      dec_res = QNAN;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      dec_res = QNAN;
    end else if (a_inf) begin
      dec_res = {in_sign, 8'hFF, 23'h0};
    end else if (b_zero) begin
      dec_res = {in_sign, 8'hFF, 23'h0};
      dec_dbz = 1'b1;
    end else begin
      dec_res = {in_sign, 31'h0};
    end
  end

  logic        r_ge;
  logic [25:0] r_sel;
  logic [25:0] r_next;

  // One restoring step: subtract the divisor when it fits, then shift left
  always_comb begin
    r_ge   = (r >= {2'b00, m2});
    r_sel  = r_ge ? (r - {2'b00, m2}) : r;
    r_next = r_sel << 1;
  end

  logic signed [9:0] norm_exp;
  logic [22:0]       norm_frac;
  logic [31:0]       norm_res;

  // Normalize the quotient and clamp to infinity or zero on range exit
  always_comb begin
    if (q[24]) begin
      norm_exp  = exp_e;
      norm_frac = q[23:1];
    end else begin
      norm_exp  = exp_e - 10'sd1;
      norm_frac = q[22:0];
    end
    if (norm_exp >= 10'sd255) begin
      norm_res = {sign, 8'hFF, 23'h0};
    end else if (norm_exp <= 10'sd0) begin
      norm_res = {sign, 31'h0};
    end else begin
      norm_res = {sign, norm_exp[7:0], norm_frac};
    end
  end

  // Control FSM with registered busy/done/result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= 32'h0;
      div_by_zero <= 1'b0;
      sign        <= 1'b0;
      m2          <= 24'h0;
      r           <= 26'h0;
      q           <= 25'h0;
      exp_e       <= 10'sd0;
      cnt         <= 5'd0;
      spec_res    <= 32'h0;
      spec_dbz    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign     <= in_sign;
            m2       <= {1'b1, f2};
            r        <= {2'b01, f1};
            q        <= 25'h0;
            exp_e    <= in_exp;
            cnt      <= 5'd0;
            spec_res <= dec_res;
            spec_dbz <= dec_dbz;
            busy     <= 1'b1;
            state    <= in_special ? FIN : DIV;
          end
        end
        DIV: begin
          q <= {q[23:0], r_ge};
          r <= r_next;
          if (cnt == 5'd24) begin
            cnt   <= 5'd0;
            state <= NORM;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        NORM: begin
          result      <= norm_res;
          div_by_zero <= 1'b0;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        FIN: begin
          result      <= spec_res;
          div_by_zero <= spec_dbz;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divider.sv
// tb_fp_divider: directed and randomized checks of fp_divider.
// The reference model computes the quotient as floor(m1 * 2^24 / m2) with
// integer division, then applies the normalize and special-case rules.

module tb_fp_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  fp_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .data1       (data1),
    .data2       (data2),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  // Single comparison point: counts and reports every check
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; presents start for one rising edge, then scrambles operands
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    data1 = a;
    data2 = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    data1 = $urandom;
    data2 = $urandom;
  endtask

  // Counts edges until done. Busy must stay high until done and be low with done.
  task automatic waitDone(input string tag, output int lat);
    int bad;
    bad = 0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1) bad++;
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    else if (busy !== 1'b0) bad++;
    checkOutput({tag, "_busy"}, bad, 32'd0);
  endtask

  // Behavioural reference for one division
  function automatic void refDiv(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output logic dbz,
                                 output logic special);
    logic        s;
    int          ea, eb, e;
    longint      fa, fb, ma, mb, qq, frac;
    logic [7:0]  ev;
    logic [22:0] fv;
    logic        aZ, aI, aN, bZ, bI, bN;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = longint'(a[22:0]);
    fb = longint'(b[22:0]);
    aZ = (ea == 0);
    aI = (ea == 255) && (fa == 0);
    aN = (ea == 255) && (fa != 0);
    bZ = (eb == 0);
    bI = (eb == 255) && (fb == 0);
    bN = (eb == 255) && (fb != 0);
    dbz = 1'b0;
    special = aZ | aI | aN | bZ | bI | bN;
    if (aN || bN) res = 32'h7FC00000;
    else if ((aZ && bZ) || (aI && bI)) res = 32'h7FC00000;
    else if (aI) res = {s, 8'hFF, 23'h0};
    else if (bZ) begin
      res = {s, 8'hFF, 23'h0};
      dbz = 1'b1;
    end else if (aZ || bI) res = {s, 31'h0};
    else begin
      ma = (longint'(1) << 23) + fa;
      mb = (longint'(1) << 23) + fb;
      qq = (ma << 24) / mb;
      e  = ea - eb + 127;
      if (qq >= (longint'(1) << 24)) frac = (qq / 2) % (longint'(1) << 23);
      else begin
        frac = qq % (longint'(1) << 23);
        e = e - 1;
      end
      if (e >= 255) res = {s, 8'hFF, 23'h0};
      else if (e <= 0) res = {s, 31'h0};
      else begin
        ev  = e[7:0];
        fv  = frac[22:0];
        res = {s, ev, fv};
      end
    end
  endfunction

  // Random operand biased toward normals, with some zeros, infinities and NaNs
  function automatic logic [31:0] randOp();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 9);
    if (k == 0) v[30:23] = 8'h00;
    else if (k == 1) begin
      v[30:23] = 8'hFF;
      if ($urandom_range(0, 1) == 0) v[22:0] = 23'h0;
    end else if (k == 2) v[30:23] = 8'($urandom_range(1, 254));
    else v[30:23] = 8'($urandom_range(100, 154));
    return v;
  endfunction

  // One full operation checked against explicit expectations
  task automatic runCase(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expRes, input logic expDbz, input int expLat);
    int lat;
    applyStimulus(a, b);
    waitDone(tag, lat);
    checkOutput({tag, "_res"}, result, expRes);
    checkOutput({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, expDbz});
    checkOutput({tag, "_lat"}, lat, expLat);
  endtask

  initial begin
    int lat;
    int stale;
    logic [31:0] a, b, er;
    logic ed, sp;

    rst_n = 1'b0;
    start = 1'b0;
    data1 = 32'h0;
    data2 = 32'h0;
    #1;
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed cases");
    runCase("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 26);
    runCase("one_by_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 26);
    runCase("neg_onehalf", 32'hBFC00000, 32'h3F000000, 32'hC0400000, 1'b0, 26);
    runCase("neg_by_zero", 32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 1);
    runCase("zero_by_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1);
    runCase("inf_by_inf", 32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 1);
    runCase("overflow", 32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, 26);
    runCase("underflow", 32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 26);
    runCase("nan_op", 32'h3F800000, 32'h7F800001, 32'h7FC00000, 1'b0, 1);
    runCase("inf_by_zero", 32'hFF800000, 32'h00000000, 32'hFF800000, 1'b0, 1);
    runCase("one_by_inf", 32'h3F800000, 32'hFF800000, 32'h80000000, 1'b0, 1);

    $display("[TB] start while busy is ignored");
    applyStimulus(32'h40C00000, 32'h40000000);
    repeat (9) @(negedge clk);
    data1 = 32'h3F800000;
    data2 = 32'h40400000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone("ignored", lat);
    checkOutput("ignored_lat", lat + 10, 32'd26);
    checkOutput("ignored_res", result, 32'h40400000);

    $display("[TB] start during done cycle");
    applyStimulus(32'hBFC00000, 32'h3F000000);
    waitDone("b2b_first", lat);
    checkOutput("b2b_first_res", result, 32'hC0400000);
    applyStimulus(32'h3F800000, 32'h40400000);
    waitDone("b2b_second", lat);
    checkOutput("b2b_second_lat", lat, 32'd26);
    checkOutput("b2b_second_res", result, 32'h3EAAAAAA);

    $display("[TB] reset mid operation");
    applyStimulus(32'h40C00000, 32'h40000000);
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
    checkOutput("midrst_done", {31'b0, done}, 32'd0);
    checkOutput("midrst_result", result, 32'd0);
    checkOutput("midrst_dbz", {31'b0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0) stale++;
    end
    checkOutput("stale_done", stale, 32'd0);
    runCase("post_reset", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 26);

    $display("[TB] randomized cases");
    for (int i = 0; i < 40; i++) begin
      a = randOp();
      b = randOp();
      refDiv(a, b, er, ed, sp);
      runCase($sformatf("rand%0d", i), a, b, er, ed, sp ? 1 : 26);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
